// File: rtl/mem_port_arbiter_if.sv
// rtl/mem_port_arbiter_if.sv - fetch, data and memory bus bundle for the memory port arbiter
interface mem_port_arbiter_if #(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 32
);
    localparam int BE_WIDTH = DATA_WIDTH / 8;

    logic                  if_req;
    logic [ADDR_WIDTH-1:0] if_addr;
    logic                  if_ready;
    logic                  if_rvalid;
    logic [DATA_WIDTH-1:0] if_rdata;

    logic                  d_req;
    logic                  d_we;
    logic [ADDR_WIDTH-1:0] d_addr;
    logic [DATA_WIDTH-1:0] d_wdata;
    logic [BE_WIDTH-1:0]   d_be;
    logic                  d_ready;
    logic                  d_rvalid;
    logic [DATA_WIDTH-1:0] d_rdata;

    logic                  mem_en;
    logic                  mem_we;
    logic [BE_WIDTH-1:0]   mem_be;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic [DATA_WIDTH-1:0] mem_rdata;

    // Requesters and memory together form the master side.
    modport master (
        output if_req, if_addr, d_req, d_we, d_addr, d_wdata, d_be, mem_rdata,
        input  if_ready, if_rvalid, if_rdata, d_ready, d_rvalid, d_rdata,
        input  mem_en, mem_we, mem_be, mem_addr, mem_wdata
    );

    modport slave (
        input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, d_be, mem_rdata,
        output if_ready, if_rvalid, if_rdata, d_ready, d_rvalid, d_rdata,
        output mem_en, mem_we, mem_be, mem_addr, mem_wdata
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - single-port memory arbiter, data-first with bounded fetch starvation
module mem_port_arbiter #(
    parameter int ADDR_WIDTH     = 10,
    parameter int DATA_WIDTH     = 32,
    parameter int MAX_DATA_BURST = 3
) (
    input  logic               clk,
    input  logic               reset,
    mem_port_arbiter_if.slave  bus
);
    localparam int BE_WIDTH = DATA_WIDTH / 8;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_IF   = 2'd1,
        OWN_D    = 2'd2
    } owner_t;

    owner_t rd_owner;
    logic   streak_full;
    logic   if_grant;
    logic   d_grant;

    // Grants are forced low while reset is held so every output sits at zero.
    assign if_grant = !reset && bus.if_req && (!bus.d_req || streak_full);
    assign d_grant  = !reset && bus.d_req && !(bus.if_req && streak_full);

    generate
        if (MAX_DATA_BURST == 0) begin : g_no_streak
            assign streak_full = 1'b1;
        end else begin : g_streak
            localparam int SW = $clog2(MAX_DATA_BURST + 1);
            logic [SW-1:0] streak;

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    streak <= '0;
                end else if (!bus.if_req || if_grant) begin
                    streak <= '0;
                end else if (d_grant && streak != SW'(MAX_DATA_BURST)) begin
                    streak <= streak + 1'b1;
                end
            end

            assign streak_full = (streak == SW'(MAX_DATA_BURST));
        end
    endgenerate

    always_comb begin
        bus.mem_en    = 1'b0;
        bus.mem_we    = 1'b0;
        bus.mem_be    = {BE_WIDTH{1'b0}};
        bus.mem_addr  = {ADDR_WIDTH{1'b0}};
        bus.mem_wdata = {DATA_WIDTH{1'b0}};
        if (d_grant) begin
            bus.mem_en    = 1'b1;
            bus.mem_we    = bus.d_we;
            bus.mem_be    = bus.d_we ? bus.d_be : {BE_WIDTH{1'b1}};
            bus.mem_addr  = bus.d_addr;
            bus.mem_wdata = bus.d_wdata;
        end else if (if_grant) begin
            bus.mem_en    = 1'b1;
            bus.mem_be    = {BE_WIDTH{1'b1}};
            bus.mem_addr  = bus.if_addr;
        end
    end

    // Remembers which requester owns the memory's next-cycle read data.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_owner <= OWN_NONE;
        end else if (if_grant) begin
            rd_owner <= OWN_IF;
        end else if (d_grant && !bus.d_we) begin
            rd_owner <= OWN_D;
        end else begin
            rd_owner <= OWN_NONE;
        end
    end

    assign bus.if_ready  = if_grant;
    assign bus.d_ready   = d_grant;
    assign bus.if_rvalid = (rd_owner == OWN_IF);
    assign bus.d_rvalid  = (rd_owner == OWN_D);
    assign bus.if_rdata  = (rd_owner == OWN_IF) ? bus.mem_rdata : {DATA_WIDTH{1'b0}};
    assign bus.d_rdata   = (rd_owner == OWN_D)  ? bus.mem_rdata : {DATA_WIDTH{1'b0}};
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - self-checking bench for mem_port_arbiter
module tb_mem_port_arbiter;
    localparam int AW   = 10;
    localparam int DW   = 32;
    localparam int BW   = DW / 8;
    localparam int MAXB = 3;
    localparam int NW   = 1 << AW;

    logic clk = 1'b0;
    logic reset;
    logic mem_clear;
    always #5 clk = ~clk;

    mem_port_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();
    mem_port_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus0 ();

    mem_port_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_DATA_BURST(MAXB)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    mem_port_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_DATA_BURST(0)) dut0 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus0.slave)
    );

    assign bus0.if_req    = bus.if_req;
    assign bus0.if_addr   = bus.if_addr;
    assign bus0.d_req     = bus.d_req;
    assign bus0.d_we      = bus.d_we;
    assign bus0.d_addr    = bus.d_addr;
    assign bus0.d_wdata   = bus.d_wdata;
    assign bus0.d_be      = bus.d_be;
    assign bus0.mem_rdata = '0;

    function automatic logic [DW-1:0] init_word(input int a);
        if (a == 0) return 32'h02A08093;
        if (a == 1) return 32'h0150F113;
        return 32'(a) * 32'h9E3779B1;
    endfunction

    // Synchronous memory driven purely by the DUT's mem_* outputs.
    logic [DW-1:0] tb_mem [NW];
    logic          written [NW];
    logic [DW-1:0] cur;
    always @(posedge clk) begin
        if (mem_clear) begin
            for (int i = 0; i < NW; i++) written[i] <= 1'b0;
        end else if (bus.mem_en) begin
            cur = written[bus.mem_addr] ? tb_mem[bus.mem_addr] : init_word(int'(bus.mem_addr));
            if (bus.mem_we) begin
                for (int b = 0; b < BW; b++)
                    if (bus.mem_be[b]) cur[b*8 +: 8] = bus.mem_wdata[b*8 +: 8];
                tb_mem[bus.mem_addr]  <= cur;
                written[bus.mem_addr] <= 1'b1;
            end else begin
                bus.mem_rdata <= cur;
            end
        end
    end

    int errors = 0;
    int checks = 0;

    logic [DW-1:0] ref_mem [NW];
    int            ref_run;
    int            exp_pend;
    logic [DW-1:0] exp_pdata;
    int            last_win;
    logic [7:0]    hist;
    logic [DW-1:0] obs_if;
    logic [DW-1:0] obs_d;

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_outputs();
        chk("rst_if_ready", 32'(bus.if_ready), 32'd0);
        chk("rst_d_ready", 32'(bus.d_ready), 32'd0);
        chk("rst_if_rvalid", 32'(bus.if_rvalid), 32'd0);
        chk("rst_d_rvalid", 32'(bus.d_rvalid), 32'd0);
        chk("rst_if_rdata", bus.if_rdata, 32'd0);
        chk("rst_d_rdata", bus.d_rdata, 32'd0);
        chk("rst_mem_en", 32'(bus.mem_en), 32'd0);
        chk("rst_mem_we", 32'(bus.mem_we), 32'd0);
        chk("rst_mem_be", 32'(bus.mem_be), 32'd0);
        chk("rst_mem_addr", 32'(bus.mem_addr), 32'd0);
        chk("rst_mem_wdata", bus.mem_wdata, 32'd0);
        chk("rst0_if_ready", 32'(bus0.if_ready), 32'd0);
        chk("rst0_d_ready", 32'(bus0.d_ready), 32'd0);
    endtask

    // One clock cycle: drive, check at the falling edge, advance the model.
    task automatic step(input logic ifr, input logic [AW-1:0] ia, input logic dr, input logic we,
                        input logic [AW-1:0] da, input logic [DW-1:0] wd, input logic [BW-1:0] be);
        int win;
        int win0;
        logic [DW-1:0] m;
        bus.if_req  = ifr;
        bus.if_addr = ia;
        bus.d_req   = dr;
        bus.d_we    = we;
        bus.d_addr  = da;
        bus.d_wdata = wd;
        bus.d_be    = be;
        @(negedge clk);

        chk("if_rvalid", 32'(bus.if_rvalid), 32'(exp_pend == 1));
        chk("d_rvalid", 32'(bus.d_rvalid), 32'(exp_pend == 2));
        chk("if_rdata", bus.if_rdata, (exp_pend == 1) ? exp_pdata : 32'd0);
        chk("d_rdata", bus.d_rdata, (exp_pend == 2) ? exp_pdata : 32'd0);

        if (ifr && dr) win = (ref_run >= MAXB) ? 1 : 2;
        else if (ifr)  win = 1;
        else if (dr)   win = 2;
        else           win = 0;
        win0 = ifr ? 1 : (dr ? 2 : 0);

        chk("if_ready", 32'(bus.if_ready), 32'(win == 1));
        chk("d_ready", 32'(bus.d_ready), 32'(win == 2));
        chk("mem_en", 32'(bus.mem_en), 32'(win != 0));
        chk("mem_we", 32'(bus.mem_we), 32'(win == 2 && we));
        chk("mem_addr", 32'(bus.mem_addr), (win == 1) ? 32'(ia) : (win == 2) ? 32'(da) : 32'd0);
        chk("mem_be", 32'(bus.mem_be), (win == 2 && we) ? 32'(be) : (win != 0) ? 32'hF : 32'd0);
        if (win == 2 && we) chk("mem_wdata", bus.mem_wdata, wd);
        if (win == 0) chk("mem_wdata_idle", bus.mem_wdata, 32'd0);
        chk("nob_if_ready", 32'(bus0.if_ready), 32'(win0 == 1));
        chk("nob_d_ready", 32'(bus0.d_ready), 32'(win0 == 2));

        if (!ifr || win == 1) ref_run = 0;
        else if (win == 2 && ref_run < MAXB) ref_run++;

        exp_pend = 0;
        if (win == 1) begin
            exp_pend  = 1;
            exp_pdata = ref_mem[ia];
        end else if (win == 2 && !we) begin
            exp_pend  = 2;
            exp_pdata = ref_mem[da];
        end else if (win == 2) begin
            m = ref_mem[da];
            for (int b = 0; b < BW; b++) if (be[b]) m[b*8 +: 8] = wd[b*8 +: 8];
            ref_mem[da] = m;
        end
        last_win = win;
        hist   = {hist[6:0], bus.d_ready};
        obs_if = bus.if_rdata;
        obs_d  = bus.d_rdata;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        step(1'b0, '0, 1'b0, 1'b0, '0, '0, '0);
    endtask

    logic            pi_req;
    logic [AW-1:0]   pi_addr;
    logic            pd_req;
    logic            pd_we;
    logic [AW-1:0]   pd_addr;
    logic [DW-1:0]   pd_wdata;
    logic [BW-1:0]   pd_be;

    initial begin
        for (int i = 0; i < NW; i++) ref_mem[i] = init_word(i);
        ref_run  = 0;
        exp_pend = 0;
        hist     = '0;
        reset     = 1'b1;
        mem_clear = 1'b1;
        bus.if_req = 1'b1; bus.if_addr = 10'd3;
        bus.d_req  = 1'b1; bus.d_we = 1'b1; bus.d_addr = 10'd7;
        bus.d_wdata = 32'h12345678; bus.d_be = 4'hF;
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs();
        mem_clear = 1'b0;
        reset     = 1'b0;

        // fetch only
        step(1'b1, 10'd0, 1'b0, 1'b0, '0, '0, '0);
        step(1'b1, 10'd1, 1'b0, 1'b0, '0, '0, '0);
        chk("fetch_word0", obs_if, 32'h02A08093);
        idle();
        chk("fetch_word1", obs_if, 32'h0150F113);

        // data write, read, partial write, read
        step(1'b0, '0, 1'b1, 1'b1, 10'd5, 32'hDEADBEEF, 4'b1111);
        step(1'b0, '0, 1'b1, 1'b0, 10'd5, '0, '0);
        idle();
        chk("d_read_full", obs_d, 32'hDEADBEEF);
        step(1'b0, '0, 1'b1, 1'b1, 10'd5, 32'h000000AA, 4'b0001);
        step(1'b0, '0, 1'b1, 1'b0, 10'd5, '0, '0);
        idle();
        chk("d_read_partial", obs_d, 32'hDEADBEAA);

        // contention: D D D IF D D D IF
        hist = '0;
        repeat (8) step(1'b1, 10'd2, 1'b1, 1'b0, 10'd5, '0, '0);
        chk("contention_seq", 32'(hist), 32'h000000EE);

        // streak cleared by a cycle without fetch request
        hist = '0;
        repeat (2) step(1'b1, 10'd2, 1'b1, 1'b0, 10'd5, '0, '0);
        step(1'b0, '0, 1'b1, 1'b0, 10'd5, '0, '0);
        repeat (4) step(1'b1, 10'd2, 1'b1, 1'b0, 10'd5, '0, '0);
        chk("streak_clear_seq", 32'(hist[6:0]), 32'h0000007E);

        // randomized traffic with requests held until accepted
        pi_req = 1'b0; pd_req = 1'b0;
        pi_addr = '0; pd_we = 1'b0; pd_addr = '0; pd_wdata = '0; pd_be = '0;
        for (int n = 0; n < 300; n++) begin
            if (!pi_req) begin
                pi_req  = 1'($urandom_range(0, 1));
                pi_addr = AW'($urandom_range(0, 15));
            end
            if (!pd_req) begin
                pd_req   = ($urandom_range(0, 3) != 0);
                pd_we    = 1'($urandom_range(0, 1));
                pd_addr  = AW'($urandom_range(0, 15));
                pd_wdata = $urandom;
                pd_be    = BW'($urandom_range(0, 15));
            end
            step(pi_req, pi_addr, pd_req, pd_we, pd_addr, pd_wdata, pd_be);
            if (last_win == 1) pi_req = 1'b0;
            if (last_win == 2) pd_req = 1'b0;
        end
        idle();

        // asynchronous reset during a pending data read
        step(1'b0, '0, 1'b1, 1'b0, 10'd5, '0, '0);
        bus.if_req = 1'b1;
        reset = 1'b1;
        #1;
        check_reset_outputs();
        reset = 1'b0;
        ref_run  = 0;
        exp_pend = 0;
        #1;
        idle();
        idle();
        step(1'b0, '0, 1'b1, 1'b0, 10'd5, '0, '0);
        idle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Single-port memory arbiter for the RV32I core. It shares one synchronous word-addressed memory between the instruction-fetch port and the load/store data port, granting at most one access per cycle. Grant is data-first with a bounded starvation guard for fetch. It sits between the core's fetch/LSU logic and a unified instruction+data memory. Read data is returned one cycle after the grant, on the response channel of the requester that issued the read.

## Interface
- ADDR_WIDTH, 10, word-address width (1024 words)
- DATA_WIDTH, 32, data word width; byte enables are DATA_WIDTH/8 bits
- MAX_DATA_BURST, 3, consecutive data grants allowed while fetch waits; 0 means fetch always wins contention

Ports:
- clk  in  1  single clock, all state on rising edge
- reset  in  1  asynchronous, active-high; clears all state immediately
- if_req  in  1  fetch read request
- if_addr  in  ADDR_WIDTH  fetch word address
- if_ready  out  1  fetch request accepted this cycle
- if_rvalid  out  1  fetch read data valid
- if_rdata  out  DATA_WIDTH  fetch read data
- d_req  in  1  data request
- d_we  in  1  1 = write, 0 = read
- d_addr  in  ADDR_WIDTH  data word address
- d_wdata  in  DATA_WIDTH  write data
- d_be  in  DATA_WIDTH/8  write byte enables
- d_ready  out  1  data request accepted this cycle
- d_rvalid  out  1  data read data valid (reads only)
- d_rdata  out  DATA_WIDTH  data read data
- mem_en  out  1  memory access strobe
- mem_we  out  1  memory write strobe
- mem_be  out  DATA_WIDTH/8  memory byte enables
- mem_addr  out  ADDR_WIDTH  memory word address
- mem_wdata  out  DATA_WIDTH  memory write data
- mem_rdata  in  DATA_WIDTH  memory read data, valid the cycle after an enabled read

## Operation
- **Handshake.** A requester holds req and all fields stable until its ready is 1. Transfer occurs on a cycle with req && ready. if_ready and d_ready are never both 1.
- **Arbitration**, combinational each cycle:
  - Only one req: that request is granted.
  - Both req: data wins unless streak == MAX_DATA_BURST, in which case fetch wins.
- **Streak counter**, width clog2(MAX_DATA_BURST+1), sequential:
  - Increments on each data grant while if_req = 1 and fetch is not granted.
  - Clears on a fetch grant or any cycle with if_req = 0.
  - Saturates at MAX_DATA_BURST.
- **Memory drive.** On a granted request, mem_* are driven combinationally from the winner: mem_en = 1, mem_we = d_we for data and 0 for fetch, mem_be = d_be for data writes and all-ones otherwise. With no grant: mem_en = 0, mem_we = 0, other mem_* = 0.
- **Response routing.**
  - Registered rd_owner ∈ {NONE, IF, D}. Set at the edge after a granted read: fetch → IF, data read → D. A write or no grant sets NONE.
  - if_rvalid = (rd_owner == IF); d_rvalid = (rd_owner == D).
  - Each rdata output equals mem_rdata when its rvalid is 1, else 0.
  - Requesters must accept responses unconditionally; there is no response backpressure.
- Back-to-back grants every cycle are allowed. A new grant overlaps the previous read's response cycle.

## Timing
- Grant latency: ready is combinational in the same cycle as req, with no registered delay.
- Read latency: rvalid is exactly 1 cycle after the accepting edge. Data comes from mem_rdata in that cycle.
- Writes: memory is updated at the accepting edge. No response is issued.
- Reset values, held asynchronously while reset = 1:
  - rd_owner = NONE, streak = 0.
  - if_ready = d_ready = 0, if_rvalid = d_rvalid = 0, both rdata = 0.
  - mem_en = mem_we = 0, mem_be = 0, mem_addr = 0, mem_wdata = 0.
- Reset asserted mid-read: the pending response is dropped and is not replayed after reset deasserts.
- First cycle after reset release: requests are arbitrated normally with streak = 0.
- Same-address write then read on consecutive cycles: the read returns the new data, because the memory write completes at the first edge.
- MAX_DATA_BURST = 0: the counter is absent and fetch wins every contention.

## Test plan
- **Fetch only.** if_req = 1, if_addr = 0 then 1, over 2 cycles. Expect if_ready = 1 both cycles, mem_addr = 0, 1. if_rvalid = 1 on the cycles after, returning mem[0] = 0x02A08093 and mem[1] = 0x0150F113.
- **Data write then read.** d_we = 1, d_addr = 5, d_wdata = 0xDEADBEEF, d_be = 4'b1111, then a read of addr 5. Expect d_ready = 1 both cycles, no d_rvalid for the write, d_rvalid = 1 with d_rdata = 0xDEADBEEF after the read. Partial write with d_be = 4'b0001 and wdata 0x000000AA → readback 0xDEADBEAA.
- **Contention and fairness**, MAX_DATA_BURST = 3. if_req and d_req held high for 8 cycles. Grant sequence must be D, D, D, IF, D, D, D, IF. if_rvalid and d_rvalid are never 1 simultaneously.
- **Streak clear.** 2 contended data grants, then if_req = 0 for 1 cycle, then contention resumes. Expect 3 further data grants before fetch wins.
- **Async reset mid-read.** Data read of addr 5 accepted; reset pulses between edges before the response cycle. Expect d_rvalid = 0 immediately, no response after release, and all outputs at their reset values during reset.
- **MAX_DATA_BURST = 0.** Both requesting. Expect if_ready = 1 every cycle and d_ready = 0 until if_req drops.
